cache_data_array_nway: RTL and testbench

//  N-way, byte-enabled cache data store with a registered read port, write-first bypass,
//  and a burst line-fill port. Memory beats are collected into a staging line and

---
 rtl/cache_data_array_nway.sv | 170 +++++++++++++++++
 tb/tb_cache_data_array_nway.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_data_array_nway.sv
// N-way byte-enabled cache data array with a registered read port, write-first
// bypass and a burst line-fill port that stages beats and commits a whole line.
module cache_data_array_nway #(
    parameter int unsigned S_OFFSET = 5,
    parameter int unsigned S_INDEX  = 3,
    parameter int unsigned NUM_WAYS = 2,
    parameter int unsigned BEAT_W   = 64,
    localparam int unsigned S_MASK  = 2 ** S_OFFSET,
    localparam int unsigned S_LINE  = 8 * S_MASK,
    localparam int unsigned S_WAY   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic [S_INDEX-1:0] rindex,
    input  logic [S_WAY-1:0]   rway,
    output logic [S_LINE-1:0]  rdata,
    output logic               rvalid,
    input  logic [S_MASK-1:0]  write_en,
    input  logic [S_INDEX-1:0] windex,
    input  logic [S_WAY-1:0]   wway,
    input  logic [S_LINE-1:0]  wdata,
    input  logic               fill_start,
    input  logic [S_INDEX-1:0] fill_index,
    input  logic [S_WAY-1:0]   fill_way,
    input  logic               fill_valid,
    input  logic [BEAT_W-1:0]  fill_beat,
    output logic               fill_busy,
    output logic               fill_done
);

    localparam int unsigned NUM_SETS  = 2 ** S_INDEX;
    localparam int unsigned WAY_SLOTS = 2 ** S_WAY;
    localparam int unsigned NUM_BEATS = S_LINE / BEAT_W;
    localparam int unsigned S_BEAT    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [S_BEAT-1:0] LastBeat = S_BEAT'(NUM_BEATS - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StCommit} fill_state_e;

    // Way slots at or above NUM_WAYS exist only to keep indexing simple; they are
    // never written, so they read back as zero.
    logic [S_LINE-1:0] mem [NUM_SETS][WAY_SLOTS];

    fill_state_e        state_q, state_d;
    logic [S_BEAT-1:0]  cnt_q, cnt_d;
    logic [S_INDEX-1:0] fidx_q, fidx_d;
    logic [S_WAY-1:0]   fway_q, fway_d;
    logic [S_LINE-1:0]  staging_q, staging_d;
    logic [S_MASK-1:0]  sticky_q, sticky_d;

    logic              cpu_wr;
    logic              commit;
    logic              cpu_hits_fill;
    logic [S_LINE-1:0] rd_line;

    function automatic logic way_ok(input logic [S_WAY-1:0] w);
        return 32'(w) < NUM_WAYS;
    endfunction

    assign cpu_wr        = way_ok(wway) && (|write_en);
    assign commit        = (state_q == StCommit) && way_ok(fway_q);
    assign cpu_hits_fill = cpu_wr && (windex == fidx_q) && (wway == fway_q);
    assign fill_busy     = (state_q != StIdle);
    assign fill_done     = (state_q == StCommit);

    // Fill FSM next state: latch target, collect beats, then one commit cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fidx_d    = fidx_q;
        fway_d    = fway_q;
        staging_d = staging_q;
        sticky_d  = sticky_q;
        unique case (state_q)
            StIdle: begin
                if (fill_start) begin
                    fidx_d   = fill_index;
                    fway_d   = fill_way;
                    cnt_d    = '0;
                    sticky_d = '0;
                    state_d  = StCollect;
                end
            end
            StCollect: begin
                if (cpu_hits_fill) sticky_d = sticky_q | write_en;
                if (fill_valid) begin
                    staging_d[cnt_q*BEAT_W +: BEAT_W] = fill_beat;
                    if (cnt_q == LastBeat) state_d = StCommit;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            StCommit: begin
                if (cpu_hits_fill) sticky_d = sticky_q | write_en;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Fill FSM state and staging registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            fidx_q    <= '0;
            fway_q    <= '0;
            staging_q <= '0;
            sticky_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fidx_q    <= fidx_d;
            fway_q    <= fway_d;
            staging_q <= staging_d;
            sticky_q  <= sticky_d;
        end
    end

    // Array update: CPU byte writes win over the fill commit; sticky bytes are skipped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < WAY_SLOTS; w++) mem[s][w] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < WAY_SLOTS; w++) begin
                    if (w < NUM_WAYS) begin
                        for (int b = 0; b < S_MASK; b++) begin
                            if (cpu_wr && write_en[b] && windex == S_INDEX'(s)
                                && wway == S_WAY'(w)) begin
                                mem[s][w][8*b +: 8] <= wdata[8*b +: 8];
                            end else if (commit && !sticky_q[b] && fidx_q == S_INDEX'(s)
                                         && fway_q == S_WAY'(w)) begin
                                mem[s][w][8*b +: 8] <= staging_q[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Write-first read mux: same-cycle CPU bytes, then commit bytes, then the array.
    always_comb begin
        rd_line = '0;
        if (way_ok(rway)) begin
            rd_line = mem[rindex][rway];
            for (int b = 0; b < S_MASK; b++) begin
                if (cpu_wr && write_en[b] && windex == rindex && wway == rway) begin
                    rd_line[8*b +: 8] = wdata[8*b +: 8];
                end else if (commit && !sticky_q[b] && fidx_q == rindex && fway_q == rway) begin
                    rd_line[8*b +: 8] = staging_q[8*b +: 8];
                end
            end
        end
    end

    // Registered read port; rdata holds when no read is requested.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) rdata <= rd_line;
        end
    end

endmodule

// File: tb/tb_cache_data_array_nway.sv
// Self-checking bench for cache_data_array_nway: table-driven read/write vectors
// followed by directed fill, sticky, commit-collision and mid-fill reset sequences.
module tb_cache_data_array_nway;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_en;
    logic [2:0]   rindex;
    logic [0:0]   rway;
    logic [255:0] rdata;
    logic         rvalid;
    logic [31:0]  write_en;
    logic [2:0]   windex;
    logic [0:0]   wway;
    logic [255:0] wdata;
    logic         fill_start;
    logic [2:0]   fill_index;
    logic [0:0]   fill_way;
    logic         fill_valid;
    logic [63:0]  fill_beat;
    logic         fill_busy;
    logic         fill_done;

    int checks = 0;
    int errors = 0;

    cache_data_array_nway dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .rindex     (rindex),
        .rway       (rway),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .write_en   (write_en),
        .windex     (windex),
        .wway       (wway),
        .wdata      (wdata),
        .fill_start (fill_start),
        .fill_index (fill_index),
        .fill_way   (fill_way),
        .fill_valid (fill_valid),
        .fill_beat  (fill_beat),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic [2:0]   ridx;
        logic         rw;
        logic [31:0]  we;
        logic [2:0]   widx;
        logic         ww;
        logic [7:0]   wb;
        logic         exp_rv;
        logic [255:0] exp_rd;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [63:0] rep8(input logic [7:0] b);
        return {8{b}};
    endfunction

    function automatic logic [255:0] line4(input logic [7:0] b3, input logic [7:0] b2,
                                           input logic [7:0] b1, input logic [7:0] b0);
        return {rep8(b3), rep8(b2), rep8(b1), rep8(b0)};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_en = 0; rindex = 0; rway = 0;
        write_en = 0; windex = 0; wway = 0; wdata = '0;
        fill_start = 0; fill_index = 0; fill_way = 0; fill_valid = 0; fill_beat = '0;
    endtask

    task automatic rd_check(input string name, input logic [2:0] idx, input logic w,
                            input logic [255:0] exp);
        rd_en = 1; rindex = idx; rway = w;
        step();
        rd_en = 0;
        chk({name, "_rvalid"}, 256'(rvalid), 256'(1));
        chk(name, rdata, exp);
    endtask

    task automatic beat(input logic [63:0] b);
        fill_valid = 1; fill_beat = b;
        step();
        fill_valid = 0; fill_beat = '0;
    endtask

    task automatic start_fill(input logic [2:0] idx, input logic w);
        fill_start = 1; fill_index = idx; fill_way = w;
        step();
        fill_start = 0;
    endtask

    initial begin
        int done_seen;

        vecs[0] = '{1'b1, 3'd3, 1'b1, 32'h0, 3'd0, 1'b0, 8'h00, 1'b1, 256'h0};
        vecs[1] = '{1'b1, 3'd2, 1'b0, 32'h0000000F, 3'd2, 1'b0, 8'hAA, 1'b1,
                    256'hAAAAAAAA};
        vecs[2] = '{1'b1, 3'd2, 1'b0, 32'h0, 3'd0, 1'b0, 8'h00, 1'b1, 256'hAAAAAAAA};
        vecs[3] = '{1'b0, 3'd2, 1'b0, 32'hF0000000, 3'd2, 1'b0, 8'h55, 1'b0,
                    256'hAAAAAAAA};
        vecs[4] = '{1'b1, 3'd2, 1'b0, 32'h0, 3'd0, 1'b0, 8'h00, 1'b1,
                    {32'h55555555, 160'h0, 64'h00000000AAAAAAAA}};
        vecs[5] = '{1'b1, 3'd2, 1'b1, 32'h0, 3'd0, 1'b0, 8'h00, 1'b1, 256'h0};
        vecs[6] = '{1'b1, 3'd2, 1'b0, 32'h00000010, 3'd2, 1'b0, 8'h77, 1'b1,
                    {32'h55555555, 160'h0, 64'h00000077AAAAAAAA}};
        vecs[7] = '{1'b1, 3'd7, 1'b0, 32'hFFFFFFFF, 3'd7, 1'b1, 8'h3C, 1'b1, 256'h0};
        vecs[8] = '{1'b1, 3'd7, 1'b1, 32'h0, 3'd0, 1'b0, 8'h00, 1'b1, {32{8'h3C}}};

        idle_inputs();
        rst = 0;
        #12;
        chk("reset_rdata", rdata, 256'h0);
        chk("reset_rvalid", 256'(rvalid), 256'(0));
        chk("reset_busy", 256'(fill_busy), 256'(0));
        chk("reset_done", 256'(fill_done), 256'(0));
        @(negedge clk);
        rst = 1;
        step();

        // Table-driven read/write vectors
        for (int i = 0; i < 9; i++) begin
            rd_en = vecs[i].rd; rindex = vecs[i].ridx; rway = vecs[i].rw;
            write_en = vecs[i].we; windex = vecs[i].widx; wway = vecs[i].ww;
            wdata = {32{vecs[i].wb}};
            step();
            chk($sformatf("vec%0d_rvalid", i), 256'(rvalid), 256'(vecs[i].exp_rv));
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
        end
        idle_inputs();

        // Fill with gaps; a beat alongside fill_start and a fill_start mid-collect are ignored
        fill_valid = 1; fill_beat = 64'hDEADDEADDEADDEAD;
        start_fill(3'd5, 1'b1);
        fill_valid = 0;
        chk("fillA_busy_start", 256'(fill_busy), 256'(1));
        chk("fillA_done_start", 256'(fill_done), 256'(0));
        step();
        beat(rep8(8'h11));
        fill_start = 1; fill_index = 3'd0; fill_way = 1'b0;
        step();
        fill_start = 0;
        beat(rep8(8'h22));
        beat(rep8(8'h33));
        step();
        chk("fillA_busy_collect", 256'(fill_busy), 256'(1));
        chk("fillA_done_early", 256'(fill_done), 256'(0));
        beat(rep8(8'h44));
        chk("fillA_done_commit", 256'(fill_done), 256'(1));
        chk("fillA_busy_commit", 256'(fill_busy), 256'(1));
        fill_valid = 1; fill_beat = 64'hFFFFFFFFFFFFFFFF;
        step();
        fill_valid = 0;
        chk("fillA_done_after", 256'(fill_done), 256'(0));
        chk("fillA_busy_after", 256'(fill_busy), 256'(0));
        rd_check("fillA_line", 3'd5, 1'b1, line4(8'h44, 8'h33, 8'h22, 8'h11));

        // CPU write into the fill target during COLLECT survives the commit
        start_fill(3'd5, 1'b1);
        beat(rep8(8'h01));
        write_en = 32'h1; windex = 3'd5; wway = 1'b1; wdata = {32{8'h5A}};
        step();
        write_en = 0;
        beat(rep8(8'h02));
        beat(rep8(8'h03));
        beat(rep8(8'h04));
        chk("fillB_done", 256'(fill_done), 256'(1));
        step();
        rd_check("fillB_sticky", 3'd5, 1'b1,
                 {rep8(8'h04), rep8(8'h03), rep8(8'h02), 64'h010101010101015A});
        rd_check("fillB_other_way", 3'd5, 1'b0, 256'h0);

        // CPU write to the fill target in the COMMIT cycle, read in the same cycle
        start_fill(3'd5, 1'b1);
        beat(rep8(8'hA1));
        beat(rep8(8'hA2));
        beat(rep8(8'hA3));
        beat(rep8(8'hA4));
        chk("fillC_done", 256'(fill_done), 256'(1));
        write_en = 32'h2; windex = 3'd5; wway = 1'b1; wdata = {32{8'hC3}};
        rd_check("fillC_bypass", 3'd5, 1'b1,
                 {rep8(8'hA4), rep8(8'hA3), rep8(8'hA2), 64'hA1A1A1A1A1A1C3A1});
        write_en = 0;
        rd_check("fillC_stored", 3'd5, 1'b1,
                 {rep8(8'hA4), rep8(8'hA3), rep8(8'hA2), 64'hA1A1A1A1A1A1C3A1});

        // Commit and an unrelated CPU write land in the same cycle
        start_fill(3'd4, 1'b0);
        beat(rep8(8'hB1));
        beat(rep8(8'hB2));
        beat(rep8(8'hB3));
        beat(rep8(8'hB4));
        write_en = 32'hFFFFFFFF; windex = 3'd6; wway = 1'b1; wdata = {32{8'h66}};
        rd_check("fillD_commit_bypass", 3'd4, 1'b0, line4(8'hB4, 8'hB3, 8'hB2, 8'hB1));
        write_en = 0;
        rd_check("fillD_set6", 3'd6, 1'b1, {32{8'h66}});
        rd_check("fillD_set4", 3'd4, 1'b0, line4(8'hB4, 8'hB3, 8'hB2, 8'hB1));

        // Asynchronous reset in the middle of a fill
        start_fill(3'd0, 1'b0);
        beat(rep8(8'hE1));
        beat(rep8(8'hE2));
        #2;
        rst = 0;
        #1;
        chk("rstmid_busy", 256'(fill_busy), 256'(0));
        chk("rstmid_done", 256'(fill_done), 256'(0));
        chk("rstmid_rdata", rdata, 256'h0);
        @(negedge clk);
        rst = 1;
        done_seen = 0;
        fill_valid = 1; fill_beat = rep8(8'hE3);
        for (int c = 0; c < 6; c++) begin
            step();
            if (fill_done) done_seen++;
            if (c == 1) fill_valid = 0;
        end
        chk("rstmid_no_done", 256'(done_seen), 256'(0));
        chk("rstmid_busy_after", 256'(fill_busy), 256'(0));
        rd_check("rstmid_set5w1", 3'd5, 1'b1, 256'h0);
        rd_check("rstmid_set6w1", 3'd6, 1'b1, 256'h0);
        rd_check("rstmid_set2w0", 3'd2, 1'b0, 256'h0);
        rd_check("rstmid_set0w0", 3'd0, 1'b0, 256'h0);

        step();
        chk("idle_rvalid", 256'(rvalid), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
